periph_timer: RTL and testbench
===============================

Name: periph_timer

Overview:
- Memory-mapped peripheral on the CPU data bus, upstream of the instruction-decode control unit.
- Holds a reloadable 32-bit timer, LED register, switch input and system tick counter.
- Timer overflow raises IRQ, which drives the control unit's IRQ input. The control unit turns it into Interrupt (PCSrc=4) when not in kernel mode.
- The ISR acknowledges by clearing the TCON status bit.

Parameters:
- BASE_ADDR, 32'h4000_0000, base of peripheral window; decode on addr[31:5]==BASE_ADDR[31:5].
- LED_W, 8, LED register width.
- SW_W, 8, switch input width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- addr  in  32  byte address from ALU result
- MemRead  in  1  read strobe from control unit
- MemWrite  in  1  write strobe from control unit
- wdata  in  32  store data
- rdata  out  32  read data, combinational from registers
- switch  in  SW_W  asynchronous board switches
- led  out  LED_W  LED register
- IRQ  out  1  interrupt request to control unit

Behaviour:
- Register map (word offsets; addr[1:0] ignored):
  - 0x00 TH, RW: reload value.
  - 0x04 TL, RW: counter.
  - 0x08 TCON, RW: bit0 EN, bit1 IE, bit2 ST; other bits read 0.
  - 0x0C LED, RW.
  - 0x10 SW, RO: synchronized switches.
  - 0x14 SYSTICK, RO.
- Reset (reset==0 at posedge clk): TH=0, TL=0, TCON=0, led=0, SW sync flops=0, SYSTICK=0, so IRQ=0. Reset mid-count aborts immediately, with no pending interrupt kept.
- Write: on posedge clk with MemWrite=1 and address decoded, the register updates. Writes to RO or unmapped offsets are ignored. MemWrite=0 leaves all registers unchanged.
- Read: rdata = selected register when MemRead=1 and address decoded, else 32'h0. Zero latency.
- Timer, per cycle with TCON.EN=1:
  - If TL==32'hFFFF_FFFF: TL<=TH; if IE=1, ST<=1.
  - Otherwise TL<=TL+1 (mod 2^32).
- Timer with EN=0: TL holds.
- ST is sticky: it clears only by a software write of 0 to bit2 or by reset.
- IRQ = TCON[1] & TCON[2], a registered-state function with no combinational path from the bus.
- Simultaneous events:
  - CPU write to TL in an overflow cycle: the write wins, and ST still sets if IE=1.
  - CPU write to TH in an overflow cycle: TL reloads the old TH.
  - CPU write to TCON clearing ST in an overflow cycle with IE (post-write) =1: ST=1, so the hardware set wins and no interrupt is lost.
  - CPU write to TCON setting EN=0 in an overflow cycle: the write wins and TL does not reload.
- Switch input: two-flop synchronizer; SW reads the second flop, giving 2-cycle latency from switch change.
- SYSTICK: increments every cycle and wraps 32'hFFFF_FFFF -> 0.

Optional Feature:
- Macro: PERIPH_SYSTICK_EN.
- Defined: SYSTICK counter present as described.
- Undefined: no counter flops; offset 0x14 reads 32'h0 and is ignored on write.

Decomposition:
- Shared package periph_pkg:
  - Offset constants OFF_TH, OFF_TL, OFF_TCON, OFF_LED, OFF_SW, OFF_SYSTICK.
  - TCON bit indices TCON_EN=0, TCON_IE=1, TCON_ST=2.
  - Default BASE_ADDR.
- One sub-module, periph_timer_core: TH/TL/TCON registers, reload/overflow logic, IRQ output, and write ports with priority rules.
- The top level does address decode, read mux, LED, switch sync and SYSTICK.

Test Plan:
- Reset: hold reset=0 two cycles with MemWrite=1 -> all reads 0, IRQ=0, led=0.
- Overflow and reload: write TH=32'hFFFF_FFFC, TL=32'hFFFF_FFFE, TCON=3 -> TL reads FFFF_FFFF next cycle, then FFFF_FFFC; ST=1 and IRQ=1 from the cycle after the reload.
- Acknowledge: with IRQ=1 write TCON=3 -> IRQ=0 next cycle. Repeat the write in an overflow cycle -> TCON reads 7 and IRQ stays 1.
- IE masking: TCON=1 through overflow -> TL reloads, ST=0, IRQ=0. Then write TCON=3 -> still IRQ=0 until the next overflow.
- Bus decode: write 32'h5A to 0x4000000C -> led=8'h5A. Write to 0x40000010 ignored. Read 0x40000020 or MemRead=0 -> rdata=0. Switch=8'hA5 -> SW reads 32'hA5 exactly 2 cycles later.
- SYSTICK: after reset release, read at cycle N returns N. With PERIPH_SYSTICK_EN undefined, it reads 0.

Source files
------------

// File: rtl/periph_pkg.sv
// Shared constants and types for the timer/LED/switch peripheral.
// Latency: n/a (definitions only).
// Backpressure: n/a; the bus is a single-cycle strobe interface.
//
// Contents: default peripheral base address, byte offsets of the register
// map within the 32-byte window, TCON bit indices, and the write-strobe
// bundle passed from the address decoder to the timer core.
package periph_pkg;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h4000_0000;

  // Byte offsets within the window; addr[1:0] is never decoded.
  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_LED     = 5'h0C;
  localparam logic [4:0] OFF_SW      = 5'h10;
  localparam logic [4:0] OFF_SYSTICK = 5'h14;

  localparam int TCON_W  = 3;
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  // One-hot write strobes for the timer registers, already qualified
  // by MemWrite and the window decode.
  typedef struct packed {
    logic th;
    logic tl;
    logic tcon;
  } tmr_wr_t;

endpackage

// File: rtl/periph_timer_core.sv
// Reloadable 32-bit timer: TH/TL/TCON registers, overflow reload, sticky status, IRQ.
// Latency: register writes visible the cycle after the strobe; IRQ is registered state.
// Backpressure: none; every write strobe is accepted in the cycle it is presented.
//
// Ports:
//   clk, reset      system clock, synchronous active-low reset
//   i_wr            decoded write strobes for TH / TL / TCON
//   i_wdata         store data
//   o_th, o_tl      current reload value and counter
//   o_tcon          {ST, IE, EN}
//   o_irq           IE & ST, straight from flops
module periph_timer_core
  import periph_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  tmr_wr_t           i_wr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_th,
  output logic [31:0]       o_tl,
  output logic [TCON_W-1:0] o_tcon,
  output logic              o_irq
);

  logic [31:0]       r_th;
  logic [31:0]       r_tl;
  logic [TCON_W-1:0] r_tcon;

  logic [TCON_W-1:0] w_tcon_wr;
  logic              w_ovf;

  // Control bits as they stand after this cycle's CPU write. Using the
  // post-write EN/IE means clearing EN suppresses a reload in the same
  // cycle, and a freshly enabled timer starts counting immediately.
  always_comb begin
    w_tcon_wr = r_tcon;
    if (i_wr.tcon) begin
      w_tcon_wr = i_wdata[TCON_W-1:0];
    end
  end

  assign w_ovf = w_tcon_wr[TCON_EN] && (r_tl == 32'hFFFF_FFFF);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_th   <= '0;
      r_tl   <= '0;
      r_tcon <= '0;
    end else begin
      if (i_wr.th) begin
        r_th <= i_wdata;
      end

      // CPU write beats reload/increment; a reload uses the TH value
      // from before any same-cycle TH write.
      if (i_wr.tl) begin
        r_tl <= i_wdata;
      end else if (w_ovf) begin
        r_tl <= r_th;
      end else if (w_tcon_wr[TCON_EN]) begin
        r_tl <= r_tl + 32'd1;
      end

      r_tcon[TCON_EN] <= w_tcon_wr[TCON_EN];
      r_tcon[TCON_IE] <= w_tcon_wr[TCON_IE];
      // Hardware set wins over a software clear so no overflow is lost.
      r_tcon[TCON_ST] <= w_tcon_wr[TCON_ST] | (w_ovf & w_tcon_wr[TCON_IE]);
    end
  end

  assign o_th   = r_th;
  assign o_tl   = r_tl;
  assign o_tcon = r_tcon;
  assign o_irq  = r_tcon[TCON_IE] & r_tcon[TCON_ST];

endmodule

// File: rtl/periph_timer.sv
// Memory-mapped peripheral: timer, LED register, synchronized switches, optional SYSTICK.
// Latency: reads are combinational (zero cycles); writes land on the next clk edge.
// Backpressure: none; MemRead/MemWrite strobes are always accepted.
//
// Optional feature macro: PERIPH_SYSTICK_EN (free-running cycle counter at 0x14;
// when undefined, no counter flops exist and 0x14 reads zero).
//
// Ports:
//   clk, reset            system clock, synchronous active-low reset
//   addr                  byte address; window hit when addr[31:5]==BASE_ADDR[31:5]
//   MemRead, MemWrite     bus strobes
//   wdata / rdata         store data / read data (zero when not selected)
//   switch                asynchronous board switches
//   led                   LED register
//   IRQ                   timer interrupt request
module periph_timer
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          LED_W     = 8,
  parameter int          SW_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [SW_W-1:0]  switch,
  output logic [LED_W-1:0] led,
  output logic             IRQ
);

  logic              w_hit;
  logic [4:0]        w_off;
  logic              w_wr;
  tmr_wr_t           w_tmr_wr;
  logic [31:0]       w_th;
  logic [31:0]       w_tl;
  logic [TCON_W-1:0] w_tcon;
  logic [31:0]       w_systick;
  logic              w_unused;

  logic [LED_W-1:0]  r_led;
  logic [SW_W-1:0]   r_sw_meta;
  logic [SW_W-1:0]   r_sw_sync;

  assign w_hit    = (addr[31:5] == BASE_ADDR[31:5]);
  assign w_off    = {addr[4:2], 2'b00};
  assign w_wr     = MemWrite & w_hit;
  // Byte lane bits are deliberately ignored by the decoder.
  assign w_unused = ^addr[1:0];

  always_comb begin
    w_tmr_wr      = '0;
    w_tmr_wr.th   = w_wr && (w_off == OFF_TH);
    w_tmr_wr.tl   = w_wr && (w_off == OFF_TL);
    w_tmr_wr.tcon = w_wr && (w_off == OFF_TCON);
  end

  periph_timer_core u_core (
    .clk     (clk),
    .reset   (reset),
    .i_wr    (w_tmr_wr),
    .i_wdata (wdata),
    .o_th    (w_th),
    .o_tl    (w_tl),
    .o_tcon  (w_tcon),
    .o_irq   (IRQ)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_led <= '0;
    end else if (w_wr && (w_off == OFF_LED)) begin
      r_led <= wdata[LED_W-1:0];
    end
  end

  assign led = r_led;

  // Two-flop synchronizer; software sees a switch change two edges later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= switch;
      r_sw_sync <= r_sw_meta;
    end
  end

`ifdef PERIPH_SYSTICK_EN
  logic [31:0] r_systick;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_systick <= '0;
    end else begin
      r_systick <= r_systick + 32'd1;
    end
  end

  assign w_systick = r_systick;
`else
  assign w_systick = 32'h0;
`endif

  always_comb begin
    rdata = 32'h0;
    if (MemRead && w_hit) begin
      case (w_off)
        OFF_TH:      rdata = w_th;
        OFF_TL:      rdata = w_tl;
        OFF_TCON:    rdata = 32'(w_tcon);
        OFF_LED:     rdata = 32'(r_led);
        OFF_SW:      rdata = 32'(r_sw_sync);
        OFF_SYSTICK: rdata = w_systick;
        default:     rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_timer.sv
// Scoreboard bench for periph_timer: stimulus queues expectations, a negedge monitor compares.
// Latency: each stimulus step occupies exactly one clock cycle.
// Backpressure: n/a.
module tb_periph_timer;

  localparam logic [31:0] B         = 32'h4000_0000;
  localparam logic [31:0] A_TH      = B + 32'h00;
  localparam logic [31:0] A_TL      = B + 32'h04;
  localparam logic [31:0] A_TCON    = B + 32'h08;
  localparam logic [31:0] A_LED     = B + 32'h0C;
  localparam logic [31:0] A_SW      = B + 32'h10;
  localparam logic [31:0] A_SYSTICK = B + 32'h14;

`ifdef PERIPH_SYSTICK_EN
  localparam logic [31:0] EXP_TICK4 = 32'd4;
`else
  localparam logic [31:0] EXP_TICK4 = 32'd0;
`endif

  typedef struct {
    logic [31:0] v;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  switch = '0;
  logic [7:0]  led;
  logic        IRQ;

  logic chk_r = 1'b0;
  logic chk_i = 1'b0;
  logic chk_l = 1'b0;
  logic done  = 1'b0;

  exp_t q_rd[$];
  exp_t q_irq[$];
  exp_t q_led[$];

  int checks = 0;
  int errors = 0;

  periph_timer dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .wdata    (wdata),
    .rdata    (rdata),
    .switch   (switch),
    .led      (led),
    .IRQ      (IRQ)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic cmp(input string nm, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: %s got %h expected %h", nm, what, act, exp);
    end
  endtask

  task automatic pop_cmp(inout exp_t q[$], input string what, input logic [31:0] act);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no expectation queued, got %h", what, act);
    end else begin
      e = q.pop_front();
      cmp(e.nm, what, act, e.v);
    end
  endtask

  always @(negedge clk) begin
    if (chk_r) pop_cmp(q_rd, "rdata", rdata);
    if (chk_i) pop_cmp(q_irq, "IRQ", {31'b0, IRQ});
    if (chk_l) pop_cmp(q_led, "led", {24'b0, led});
    if (done) begin
      cmp("drain", "pending expectations", 32'(q_rd.size() + q_irq.size() + q_led.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input bit rd, input bit cr, input logic [31:0] er,
                      input bit ci, input bit ei, input bit cl, input logic [7:0] el,
                      input string nm);
    MemWrite = wr;
    MemRead  = rd;
    addr     = a;
    wdata    = d;
    chk_r    = cr;
    chk_i    = ci;
    chk_l    = cl;
    if (cr) q_rd.push_back('{v: er, nm: nm});
    if (ci) q_irq.push_back('{v: {31'b0, ei}, nm: nm});
    if (cl) q_led.push_back('{v: {24'b0, el}, nm: nm});
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    chk_r    = 1'b0;
    chk_i    = 1'b0;
    chk_l    = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    tick(1, a, d, 0, 0, 0, 0, 0, 0, 0, "wr");
  endtask
  task automatic wri(input logic [31:0] a, input logic [31:0] d, input bit ei, input string nm);
    tick(1, a, d, 0, 0, 0, 1, ei, 0, 0, nm);
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    tick(0, a, 0, 1, 1, e, 0, 0, 0, 0, nm);
  endtask
  task automatic rdi(input logic [31:0] a, input logic [31:0] e, input bit ei, input string nm);
    tick(0, a, 0, 1, 1, e, 1, ei, 0, 0, nm);
  endtask
  task automatic chkirq(input bit ei, input string nm);
    tick(0, 0, 0, 0, 0, 0, 1, ei, 0, 0, nm);
  endtask
  task automatic chkled(input logic [7:0] el, input string nm);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 1, el, nm);
  endtask
  task automatic idle();
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
  endtask

  initial begin
    // Reset held with write strobes active: nothing may land.
    reset = 1'b0;
    wr(A_TH, 32'hFFFF_FFFF);
    wr(A_LED, 32'h0000_00FF);
    rdi(A_TH, 32'h0, 0, "rst_th");
    rd(A_TL, 32'h0, "rst_tl");
    rd(A_TCON, 32'h0, "rst_tcon");
    rd(A_LED, 32'h0, "rst_led_reg");
    rd(A_SW, 32'h0, "rst_sw");
    chkled(8'h00, "rst_led_port");

    // SYSTICK: cycle N after release reads N.
    reset = 1'b1;
    rd(A_SYSTICK, 32'h0, "systick_c0");
    idle();
    idle();
    idle();
    rd(A_SYSTICK, EXP_TICK4, "systick_c4");

    // Overflow and reload.
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h3);                                  // TL -> FFFF_FFFF
    rdi(A_TL, 32'hFFFF_FFFF, 0, "ovf_pre");              // overflow at end
    rdi(A_TL, 32'hFFFF_FFFC, 1, "ovf_reload");
    rdi(A_TCON, 32'h7, 1, "ovf_st");                     // TL -> FFFF_FFFE

    // Acknowledge, then acknowledge racing an overflow.
    wr(A_TCON, 32'h3);                                   // ST=0, TL -> FFFF_FFFF
    wri(A_TCON, 32'h3, 0, "ack_irq_low");                // overflow cycle
    rdi(A_TCON, 32'h7, 1, "ack_race");                   // TL -> FFFF_FFFD
    wr(A_TCON, 32'h3);                                   // TL -> FFFF_FFFE

    // IE masking; upper TCON bits written as ones must read back zero.
    wr(A_TCON, 32'hFFFF_FFF9);                           // EN only, TL -> FFFF_FFFF
    rdi(A_TL, 32'hFFFF_FFFF, 0, "mask_pre");
    rdi(A_TL, 32'hFFFF_FFFC, 0, "mask_reload");
    rdi(A_TCON, 32'h1, 0, "mask_tcon");                  // TL -> FFFF_FFFE
    wr(A_TCON, 32'h3);                                   // TL -> FFFF_FFFF
    rdi(A_TCON, 32'h3, 0, "mask_ie_on");                 // overflow cycle
    chkirq(1, "mask_next_ovf");                          // TL -> FFFF_FFFD

    // EN=0 holds TL; TL write racing an overflow.
    wr(A_TCON, 32'h2);
    wr(A_TL, 32'hFFFF_FFFD);
    rdi(A_TL, 32'hFFFF_FFFD, 0, "en0_hold");
    wr(A_TCON, 32'h3);                                   // TL -> FFFF_FFFE
    idle();                                              // TL -> FFFF_FFFF
    wr(A_TL, 32'h0000_1234);                             // overflow cycle
    rdi(A_TL, 32'h0000_1234, 1, "tl_wr_race");

    // TH write racing an overflow: reload uses old TH.
    wr(A_TCON, 32'h3);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TH, 32'h0000_0050);                             // overflow cycle
    rdi(A_TL, 32'hFFFF_FFFC, 1, "th_wr_race_tl");
    rd(A_TH, 32'h0000_0050, "th_wr_race_th");            // TL -> FFFF_FFFE
    idle();                                              // TL -> FFFF_FFFF

    // EN cleared in the overflow cycle: no reload.
    wr(A_TCON, 32'h2);
    rdi(A_TL, 32'hFFFF_FFFF, 0, "en_off_race");
    rd(A_TCON, 32'h2, "en_off_tcon");

    // Bus decode.
    wr(A_LED, 32'h0000_005A);
    chkled(8'h5A, "led_wr");
    wr(A_SW, 32'h0000_00FF);
    wr(B + 32'h18, 32'hFFFF_FFFF);
    wr(32'h5000_000C, 32'h0000_0011);
    chkled(8'h5A, "led_hold");
    rd(B + 32'h0F, 32'h0000_005A, "byte_lane_ignored");
    rd(A_SW, 32'h0, "sw_ro");
    rd(B + 32'h18, 32'h0, "unmapped_rd");
    rd(B + 32'h20, 32'h0, "out_of_window_rd");
    tick(0, A_LED, 0, 0, 1, 32'h0, 0, 0, 0, 0, "no_memread");
    rd(A_TH, 32'h0000_0050, "th_after_stray");

    // Switch synchronizer latency.
    switch = 8'hA5;
    rd(A_SW, 32'h0, "sw_c0");
    rd(A_SW, 32'h0, "sw_c1");
    rd(A_SW, 32'h0000_00A5, "sw_c2");

    // Reset mid-count with an interrupt pending.
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h3);
    idle();
    chkirq(1, "pre_reset_irq");
    reset = 1'b0;
    idle();
    reset = 1'b1;
    rdi(A_SW, 32'h0, 0, "mid_rst_sw");
    rd(A_TL, 32'h0, "mid_rst_tl");
    rd(A_TCON, 32'h0, "mid_rst_tcon");
    rd(A_TH, 32'h0, "mid_rst_th");
    chkled(8'h00, "mid_rst_led");

    done = 1'b1;
    forever @(posedge clk);
  end

endmodule
